fsic_lite: RTL and testbench

- Simplified full-stack IC bridge for a Caravel-style user project area.
- Wishbone slave with a mailbox register bank and an IO-serdes control block.
- Serializes mailbox writes onto user IO pins and deserializes incoming IO beats into an RX FIFO.
- Clocked by wb_clk, which a separate divider block (fsic_clock_div) derives from ioclk; that divider is out of scope here.

---
 rtl/fsic_lite.sv | 228 ++++++++++++++++++++++
 tb/tb_fsic_lite.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fsic_lite.sv
// Simplified FSIC bridge: Wishbone mailbox/serdes registers, a framed IO serializer for
// mailbox writes and an IO deserializer feeding an RX FIFO.
module fsic_lite #(
  parameter int pSERIALIO_WIDTH = 12,
  parameter int pADDR_WIDTH     = 10,
  parameter int pDATA_WIDTH     = 32,
  parameter int pRxFIFO_DEPTH   = 5,
  parameter int pCLK_RATIO      = 4
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [31:0]            wbs_adr,
  input  logic [pDATA_WIDTH-1:0] wbs_wdata,
  input  logic [3:0]             wbs_sel,
  input  logic                   wbs_cyc,
  input  logic                   wbs_stb,
  input  logic                   wbs_we,
  output logic                   wbs_ack,
  output logic [pDATA_WIDTH-1:0] wbs_rdata,
  input  logic [127:0]           la_data_in,
  input  logic [127:0]           la_oenb,
  output logic [127:0]           la_data_out,
  input  logic [37:0]            io_in,
  output logic [37:0]            io_out,
  output logic [37:0]            io_oeb,
  output logic [2:0]             user_irq,
  input  logic                   user_clock2,
  input  logic                   vccd1,
  input  logic                   vccd2,
  input  logic                   vssd1,
  input  logic                   vssd2
);
  localparam int S        = pDATA_WIDTH / pCLK_RATIO;
  localparam int P        = pSERIALIO_WIDTH;
  localparam int CW       = $clog2(pCLK_RATIO);
  localparam int FW       = $clog2(pRxFIFO_DEPTH + 1);
  localparam int PW       = $clog2(pRxFIFO_DEPTH);
  localparam int IW       = pADDR_WIDTH - 2;
  localparam int MB_WORDS = 8;

  function automatic logic [pDATA_WIDTH-1:0] byte_merge(
    input logic [pDATA_WIDTH-1:0] old_w, input logic [pDATA_WIDTH-1:0] new_w,
    input logic [3:0] sel);
    logic [pDATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < pDATA_WIDTH / 8; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  logic                   ack_r, rxen_r, txen_r, ovf_r, tx_busy_r;
  logic [pDATA_WIDTH-1:0] rdata_r, tx_shift_r, rx_word_r;
  logic [pDATA_WIDTH-1:0] mbox_r [MB_WORDS];
  logic [pDATA_WIDTH-1:0] fifo_mem_r [pRxFIFO_DEPTH];
  logic [S+1:0]           tx_out_r;
  logic [CW-1:0]          tx_cnt_r, rx_cnt_r;
  logic [PW-1:0]          rd_ptr_r, wr_ptr_r;
  logic [FW-1:0]          fifo_cnt_r;

  logic                   hit_s, mbox_sel_s, ser_sel_s, req_s, stall_s, accept_s, wr_s, rd_s;
  logic                   ctrl_wr_s, stat_wr_s, pop_s, tx_load_s, txen_nxt_s;
  logic                   rx_push_s, fifo_full_s, push_ok_s, ovf_set_s, ovf_clr_s;
  logic [IW-1:0]          word_idx_s;
  logic [2:0]             mb_idx_s;
  logic [CW-1:0]          rx_pos_s;
  logic [pDATA_WIDTH-1:0] mb_new_s, rd_val_s, status_s, rx_word_s;
  logic                   unused_ok_s;

  assign unused_ok_s = ^{la_data_in, la_oenb, io_in, wbs_adr, user_clock2,
                         vccd1, vccd2, vssd1, vssd2};

  // Address decode, transfer acceptance and register-side strobes
  always_comb begin
    hit_s      = (wbs_adr[31:16] == 16'h3000);
    word_idx_s = wbs_adr[pADDR_WIDTH-1:2];
    mb_idx_s   = word_idx_s[2:0];
    mbox_sel_s = hit_s && (wbs_adr[15:12] == 4'h2) && (word_idx_s < IW'(MB_WORDS));
    ser_sel_s  = hit_s && (wbs_adr[15:12] == 4'h3);
    req_s      = wbs_cyc && wbs_stb && !ack_r;
    // A mailbox write that would start a frame waits for the serializer to drain
    stall_s    = mbox_sel_s && wbs_we && txen_r && tx_busy_r;
    accept_s   = req_s && !stall_s;
    wr_s       = accept_s && wbs_we;
    rd_s       = accept_s && !wbs_we;
    ctrl_wr_s  = wr_s && ser_sel_s && (word_idx_s == IW'(0));
    stat_wr_s  = wr_s && ser_sel_s && (word_idx_s == IW'(1));
    pop_s      = rd_s && ser_sel_s && (word_idx_s == IW'(2)) && (fifo_cnt_r != FW'(0));
    mb_new_s   = byte_merge(mbox_r[mb_idx_s], wbs_wdata, wbs_sel);
    tx_load_s  = wr_s && mbox_sel_s && txen_r;
    if (ctrl_wr_s && wbs_sel[0]) begin
      txen_nxt_s = wbs_wdata[1];
    end else begin
      txen_nxt_s = txen_r;
    end
  end

  // Read data mux
  always_comb begin
    status_s         = '0;
    status_s[FW-1:0] = fifo_cnt_r;
    status_s[4]      = tx_busy_r;
    status_s[8]      = ovf_r;
    rd_val_s         = '0;
    if (mbox_sel_s) begin
      rd_val_s = mbox_r[mb_idx_s];
    end else if (ser_sel_s) begin
      case (word_idx_s)
        IW'(0):  rd_val_s = {30'd0, txen_r, rxen_r};
        IW'(1):  rd_val_s = status_s;
        IW'(2):  rd_val_s = (fifo_cnt_r != FW'(0)) ? fifo_mem_r[rd_ptr_r] : '0;
        default: rd_val_s = '0;
      endcase
    end else begin
      rd_val_s = '0;
    end
  end

  // Deserializer beat assembly and FIFO push/overflow decisions
  always_comb begin
    rx_word_s = rx_word_r;
    rx_pos_s  = io_in[P+S+1] ? CW'(0) : rx_cnt_r;
    rx_word_s[int'(rx_pos_s)*S +: S] = io_in[P+S-1 -: S];
    rx_push_s   = rxen_r && io_in[P+S] && (rx_pos_s == CW'(pCLK_RATIO - 1));
    fifo_full_s = (fifo_cnt_r == FW'(pRxFIFO_DEPTH));
    push_ok_s   = rx_push_s && (!fifo_full_s || pop_s);
    ovf_set_s   = rx_push_s && fifo_full_s && !pop_s;
    ovf_clr_s   = stat_wr_s && wbs_sel[1] && wbs_wdata[8];
  end

  // Wishbone acknowledge and registered read data
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      ack_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      ack_r   <= accept_s;
      rdata_r <= rd_s ? rd_val_s : '0;
    end
  end

  // Control enables and sticky overflow flag
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      rxen_r <= 1'b0;
      txen_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      txen_r <= txen_nxt_s;
      if (ctrl_wr_s && wbs_sel[0]) rxen_r <= wbs_wdata[0];
      if (ovf_set_s) ovf_r <= 1'b1;
      else if (ovf_clr_s) ovf_r <= 1'b0;
    end
  end

  // Mailbox register bank
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      for (int i = 0; i < MB_WORDS; i++) mbox_r[i] <= '0;
    end else if (wr_s && mbox_sel_s) begin
      mbox_r[mb_idx_s] <= mb_new_s;
    end
  end

  // Serializer: beat 0 is presented on the accepting edge, LSB slice first
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      tx_busy_r  <= 1'b0;
      tx_out_r   <= '0;
      tx_shift_r <= '0;
      tx_cnt_r   <= '0;
    end else if (tx_load_s) begin
      tx_busy_r  <= 1'b1;
      tx_out_r   <= {1'b1, 1'b1, mb_new_s[S-1:0]};
      tx_shift_r <= mb_new_s >> S;
      tx_cnt_r   <= CW'(pCLK_RATIO - 1);
    end else if (tx_busy_r) begin
      if (!txen_nxt_s || (tx_cnt_r == CW'(0))) begin
        tx_busy_r <= 1'b0;
        tx_out_r  <= '0;
      end else begin
        tx_out_r   <= {1'b0, 1'b1, tx_shift_r[S-1:0]};
        tx_shift_r <= tx_shift_r >> S;
        tx_cnt_r   <= tx_cnt_r - CW'(1);
      end
    end
  end

  // Deserializer beat counter and partial word
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      rx_cnt_r  <= '0;
      rx_word_r <= '0;
    end else if (!rxen_r) begin
      rx_cnt_r <= '0;
    end else if (io_in[P+S]) begin
      rx_word_r <= rx_word_s;
      rx_cnt_r  <= rx_push_s ? CW'(0) : rx_pos_s + CW'(1);
    end
  end

  // RX FIFO storage, pointers and occupancy
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_cnt_r <= '0;
      for (int i = 0; i < pRxFIFO_DEPTH; i++) fifo_mem_r[i] <= '0;
    end else begin
      if (push_ok_s) begin
        fifo_mem_r[wr_ptr_r] <= rx_word_s;
        wr_ptr_r <= (wr_ptr_r == PW'(pRxFIFO_DEPTH - 1)) ? PW'(0) : wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(pRxFIFO_DEPTH - 1)) ? PW'(0) : rd_ptr_r + PW'(1);
      end
      fifo_cnt_r <= fifo_cnt_r + FW'(push_ok_s) - FW'(pop_s);
    end
  end

  assign wbs_ack     = ack_r;
  assign wbs_rdata   = rdata_r;
  assign io_out      = {{(38 - S - 2){1'b0}}, tx_out_r};
  assign io_oeb      = {{(38 - P){1'b1}}, {P{~txen_r}}};
  assign user_irq    = {1'b0, ovf_r, (fifo_cnt_r != FW'(0))};
  assign la_data_out = {96'd0, mbox_r[0]};

endmodule

// File: tb/tb_fsic_lite.sv
// Directed self-checking bench for fsic_lite: register access, TX framing, RX FIFO,
// overflow, byte masking, unmapped addresses and asynchronous reset.
module tb_fsic_lite;
  logic         wb_clk = 1'b0;
  logic         wb_rst;
  logic [31:0]  wbs_adr, wbs_wdata, wbs_rdata;
  logic [3:0]   wbs_sel;
  logic         wbs_cyc, wbs_stb, wbs_we, wbs_ack;
  logic [127:0] la_data_in, la_oenb, la_data_out;
  logic [37:0]  io_in, io_out, io_oeb;
  logic [2:0]   user_irq;

  int checks = 0;
  int errors = 0;
  logic [9:0] cap_q[$];

  localparam logic [31:0] CTRL   = 32'h3000_3000;
  localparam logic [31:0] STATUS = 32'h3000_3004;
  localparam logic [31:0] RXDATA = 32'h3000_3008;

  fsic_lite dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata),
    .wbs_sel(wbs_sel), .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
    .wbs_ack(wbs_ack), .wbs_rdata(wbs_rdata), .la_data_in(la_data_in), .la_oenb(la_oenb),
    .la_data_out(la_data_out), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .user_irq(user_irq), .user_clock2(1'b0), .vccd1(1'b1), .vccd2(1'b1),
    .vssd1(1'b0), .vssd2(1'b0)
  );

  always #5 wb_clk = ~wb_clk;

  always @(negedge wb_clk) begin
    if (io_out[8]) cap_q.push_back(io_out[9:0]);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] wdata, input logic [3:0] sel,
                         input logic we, output logic [31:0] rdata, output int waits);
    logic got;
    wbs_adr = adr; wbs_wdata = wdata; wbs_sel = sel; wbs_we = we;
    wbs_cyc = 1'b1; wbs_stb = 1'b1;
    waits = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge wb_clk); #1;
      waits++;
      if (wbs_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_seen", got, 1'b1);
    rdata = wbs_rdata;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] wdata, input logic [3:0] sel);
    logic [31:0] d;
    int w;
    wb_xfer(adr, wdata, sel, 1'b1, d, w);
  endtask

  task automatic wb_rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    wb_xfer(adr, 32'h0, 4'hF, 1'b0, d, w);
    chk(tag, d, exp);
  endtask

  task automatic rx_frame(input logic [31:0] word);
    for (int k = 0; k < 4; k++) begin
      io_in = '0;
      io_in[19:12] = word[8*k +: 8];
      io_in[20] = 1'b1;
      io_in[21] = (k == 0);
      @(posedge wb_clk); #1;
    end
    io_in = '0;
  endtask

  initial begin
    logic [31:0] d;
    int w1, w2;
    logic [9:0] exp_b2b [8];
    exp_b2b = '{10'h344, 10'h133, 10'h122, 10'h111, 10'h388, 10'h177, 10'h166, 10'h155};

    wb_rst = 1'b0; wbs_adr = '0; wbs_wdata = '0; wbs_sel = '0;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    la_data_in = '0; la_oenb = '0; io_in = '0;
    #2;
    chk("rst_ack", wbs_ack, 1'b0);
    chk("rst_rdata", wbs_rdata, 32'h0);
    chk("rst_io_out", io_out, 38'h0);
    chk("rst_io_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    chk("rst_irq", user_irq, 3'b000);
    chk("rst_la", la_data_out, 128'h0);
    #10 wb_rst = 1'b1;

    // CTRL rxen only; one-cycle ack
    wb_wr(CTRL, 32'h1, 4'b0001);
    @(posedge wb_clk); #1;
    chk("ack_one_cycle", wbs_ack, 1'b0);
    wb_rd_chk("ctrl_rd", CTRL, 32'h1);
    chk("oeb_txen0", io_oeb[11:0], 12'hFFF);

    // Single TX frame
    wb_wr(CTRL, 32'h3, 4'hF);
    chk("oeb_txen1", io_oeb, 38'h3F_FFFF_F000);
    wb_wr(32'h3000_2000, 32'hA5A5_A5A5, 4'hF);
    chk("tx_beat0", io_out, 38'h3A5);
    for (int k = 1; k < 4; k++) begin
      @(posedge wb_clk); #1;
      chk("tx_beat_n", io_out, 38'h1A5);
    end
    @(posedge wb_clk); #1;
    chk("tx_idle", io_out, 38'h0);
    chk("la_mbox0", la_data_out, 128'hA5A5_A5A5);

    // Back-to-back mailbox writes: second stalls until the first frame drains
    cap_q.delete();
    wb_xfer(32'h3000_2004, 32'h1122_3344, 4'hF, 1'b1, d, w1);
    wb_xfer(32'h3000_2008, 32'h5566_7788, 4'hF, 1'b1, d, w2);
    chk("b2b_wait1", w1, 1);
    chk("b2b_wait2", w2, 5);
    repeat (6) @(posedge wb_clk);
    #1;
    chk("b2b_beats", cap_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("b2b_beat", cap_q[i], exp_b2b[i]);

    // RX single word
    repeat (4) @(posedge wb_clk);
    #1;
    rx_frame(32'h1234_5678);
    wb_rd_chk("rx_status1", STATUS, 32'h1);
    chk("rx_irq0", user_irq, 3'b001);
    wb_rd_chk("rx_data", RXDATA, 32'h1234_5678);
    wb_rd_chk("rx_status0", STATUS, 32'h0);
    wb_rd_chk("rx_empty_rd", RXDATA, 32'h0);

    // Overflow: six words into a five-entry FIFO
    for (int i = 0; i < 6; i++) rx_frame(32'h0101_0101 * (i + 1));
    wb_rd_chk("ovf_status", STATUS, 32'h105);
    chk("ovf_irq", user_irq, 3'b011);
    wb_wr(STATUS, 32'h100, 4'b0010);
    wb_rd_chk("ovf_clr", STATUS, 32'h5);
    chk("ovf_irq_clr", user_irq, 3'b001);
    wb_rd_chk("ovf_head", RXDATA, 32'h0101_0101);
    wb_rd_chk("ovf_cnt4", STATUS, 32'h4);

    // Byte-masked write and unmapped addresses
    wb_wr(32'h3000_200C, 32'hAABB_FFCC, 4'b0010);
    wb_rd_chk("sel_mask", 32'h3000_200C, 32'h0000_FF00);
    wb_wr(32'h3001_0000, 32'hDEAD_BEEF, 4'hF);
    wb_rd_chk("bad_adr", 32'h3001_0000, 32'h0);
    wb_rd_chk("mbox_oob", 32'h3000_2020, 32'h0);
    chk("la_intact", la_data_out, 128'hA5A5_A5A5);

    // Asynchronous reset in the middle of a frame
    repeat (6) @(posedge wb_clk);
    #1;
    wb_wr(32'h3000_2000, 32'h0F0F_0F0F, 4'hF);
    chk("pre_rst_beat0", io_out, 38'h30F);
    @(posedge wb_clk); #2;
    wb_rst = 1'b0;
    #1;
    chk("mid_rst_io_out", io_out, 38'h0);
    chk("mid_rst_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    chk("mid_rst_irq", user_irq, 3'b000);
    chk("mid_rst_la", la_data_out, 128'h0);
    chk("mid_rst_ack", wbs_ack, 1'b0);
    #3 wb_rst = 1'b1;
    wb_rd_chk("post_rst_ctrl", CTRL, 32'h0);
    wb_rd_chk("post_rst_status", STATUS, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
